spi_slave: RTL

- SPI responder; the far-end counterpart of the team's SPI master (spimaster).
- Oversamples Sclk, SS and MOSI in the local clk domain and supports all four CPOL/CPHA modes.
- Shifts out a preloaded byte on MISO while capturing the master's byte from MOSI; MSB first.
- Sits on the peripheral side of the link; the local logic sees a simple load/valid interface.

---
 rtl/spi_slave.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/spi_slave.sv
// ============================================================================
// Module   : spi_slave
// Purpose  : Oversampled SPI responder (CPOL/CPHA modes 0-3) with a
//            load/valid local interface. Define SPI_SLAVE_LSB_FIRST_EN for
//            LSB-first framing.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_slave #(
   parameter int DATA_WIDTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            MODE,
   input  logic [DATA_WIDTH-1:0] DatatoTransmit,
   input  logic                  load,
   output logic [DATA_WIDTH-1:0] DataReceived,
   output logic                  rx_valid,
   output logic                  busy,
   input  logic                  Sclk,
   input  logic                  SS,
   input  logic                  MOSI,
   output logic                  MISO
);

   localparam int              C_SYNC  = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
   localparam int              C_CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(DATA_WIDTH - 1);

   localparam logic [0:0] S_IDLE   = 1'b0;
   localparam logic [0:0] S_ACTIVE = 1'b1;

   logic [C_SYNC-1:0]     r_sclk_sync;
   logic [C_SYNC-1:0]     r_ss_sync;
   logic [C_SYNC-1:0]     r_mosi_sync;
   logic                  r_sclk_q;
   logic                  r_ss_q;

   logic [0:0]            r_state;
   logic [1:0]            r_mode_q;
   logic [DATA_WIDTH-1:0] r_tx_buf;
   logic [DATA_WIDTH-1:0] r_tx_shreg;
   logic [DATA_WIDTH-2:0] r_rx_shreg;
   logic [C_CNT_W-1:0]    r_bit_cnt;
   logic                  r_skip_drive;
   logic [DATA_WIDTH-1:0] r_data_rx;
   logic                  r_rx_valid;

   logic                  w_sclk;
   logic                  w_ss;
   logic                  w_mosi;
   logic                  w_ss_fall;
   logic                  w_ss_rise;
   logic                  w_cpol;
   logic                  w_cpha;
   logic                  w_lead;
   logic                  w_trail;
   logic                  w_sample;
   logic                  w_drive;
   logic [DATA_WIDTH-1:0] w_tx_src;
   logic [DATA_WIDTH-1:0] w_tx_shift;
   logic [DATA_WIDTH-1:0] w_rx_next;
   logic                  w_tx_bit;

   // SS synchronizer resets high so that release from reset never fakes a frame start
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sclk_sync <= '0;
         r_ss_sync   <= '1;
         r_mosi_sync <= '0;
         r_sclk_q    <= 1'b0;
         r_ss_q      <= 1'b1;
      end else begin
         r_sclk_sync <= {r_sclk_sync[C_SYNC-2:0], Sclk};
         r_ss_sync   <= {r_ss_sync[C_SYNC-2:0], SS};
         r_mosi_sync <= {r_mosi_sync[C_SYNC-2:0], MOSI};
         r_sclk_q    <= w_sclk;
         r_ss_q      <= w_ss;
      end
   end

   assign w_sclk    = r_sclk_sync[C_SYNC-1];
   assign w_ss      = r_ss_sync[C_SYNC-1];
   assign w_mosi    = r_mosi_sync[C_SYNC-1];
   assign w_ss_fall = r_ss_q & ~w_ss;
   assign w_ss_rise = ~r_ss_q & w_ss;

   assign w_cpol   = r_mode_q[1];
   assign w_cpha   = r_mode_q[0];
   assign w_lead   = (r_sclk_q == w_cpol) && (w_sclk != w_cpol);
   assign w_trail  = (r_sclk_q != w_cpol) && (w_sclk == w_cpol);
   assign w_sample = w_cpha ? w_trail : w_lead;
   assign w_drive  = w_cpha ? w_lead  : w_trail;

   // A load on the same cycle as a frame (re)load wins over the buffered byte
   assign w_tx_src = load ? DatatoTransmit : r_tx_buf;

`ifdef SPI_SLAVE_LSB_FIRST_EN
   assign w_tx_shift = {1'b0, r_tx_shreg[DATA_WIDTH-1:1]};
   assign w_rx_next  = {w_mosi, r_rx_shreg};
   assign w_tx_bit   = r_tx_shreg[0];
`else
   assign w_tx_shift = {r_tx_shreg[DATA_WIDTH-2:0], 1'b0};
   assign w_rx_next  = {r_rx_shreg, w_mosi};
   assign w_tx_bit   = r_tx_shreg[DATA_WIDTH-1];
`endif

   // r_skip_drive suppresses the one drive edge whose bit is already on MISO:
   // the first leading edge in CPHA=1, and the edge right after any reload.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_mode_q     <= 2'b00;
         r_tx_buf     <= '0;
         r_tx_shreg   <= '0;
         r_rx_shreg   <= '0;
         r_bit_cnt    <= '0;
         r_skip_drive <= 1'b0;
         r_data_rx    <= '0;
         r_rx_valid   <= 1'b0;
      end else begin
         r_rx_valid <= 1'b0;
         if (load) begin
            r_tx_buf <= DatatoTransmit;
         end
         case (r_state)
            S_IDLE: begin
               if (w_ss_fall) begin
                  r_state      <= S_ACTIVE;
                  r_mode_q     <= MODE;
                  r_rx_shreg   <= '0;
                  r_bit_cnt    <= '0;
                  r_tx_shreg   <= w_tx_src;
                  r_skip_drive <= MODE[0];
               end
            end
            S_ACTIVE: begin
               if (w_sample) begin
`ifdef SPI_SLAVE_LSB_FIRST_EN
                  r_rx_shreg <= w_rx_next[DATA_WIDTH-1:1];
`else
                  r_rx_shreg <= w_rx_next[DATA_WIDTH-2:0];
`endif
                  if (r_bit_cnt == C_LAST) begin
                     r_bit_cnt    <= '0;
                     r_data_rx    <= w_rx_next;
                     r_rx_valid   <= 1'b1;
                     r_tx_shreg   <= w_tx_src;
                     r_skip_drive <= 1'b1;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                  end
               end
               if (w_drive) begin
                  if (r_skip_drive) begin
                     r_skip_drive <= 1'b0;
                  end else begin
                     r_tx_shreg <= w_tx_shift;
                  end
               end
               if (w_ss_rise) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign DataReceived = r_data_rx;
   assign rx_valid     = r_rx_valid;
   assign busy         = (r_state == S_ACTIVE);
   assign MISO         = ((r_state == S_ACTIVE) && !w_ss) ? w_tx_bit : 1'bz;

endmodule

`default_nettype wire
